// File: rtl/snoop_pkg.sv
// Shared constants and FSM state type for the snoop dispatcher.
// The TCAM filter and its bench import this same package.
package snoop_pkg;

   localparam int unsigned N_RN_DEFAULT = 7;

   localparam logic [6:0] READ_SHARED = 7'b0000001;
   localparam logic [6:0] READ_UNIQUE = 7'b0000111;
   localparam logic [6:0] SNP_SHARED  = 7'b0000001;
   localparam logic [6:0] SNP_UNIQUE  = 7'b0000111;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } snoop_state_e;

endpackage

// File: rtl/snoop_dispatcher_lowest_one_sel.sv
// Priority select: passes only the lowest set bit of vec_i, as a one-hot vector.
module lowest_one_sel #(
   parameter int unsigned N = 7
) (
   input  logic [N-1:0] vec_i,
   output logic [N-1:0] onehot_o
);

   logic found;

   always_comb begin
      onehot_o = '0;
      found    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec_i[i] && !found) begin
            onehot_o[i] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/snoop_dispatcher.sv
// Serial snoop dispatcher for one TCAM lookup result at a time.
// Build option SNOOP_TIMEOUT_EN adds a WAIT_RSP response timeout.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | ready for a lookup result
// ST_ISSUE    | presenting a snoop to the lowest pending sharer
// ST_WAIT_RSP | waiting for that sharer's response
// ST_DONE     | presenting the completion until done_ready
module snoop_dispatcher
   import snoop_pkg::*;
#(
   parameter int unsigned WIDTH   = 33,
   parameter int unsigned N_RN    = N_RN_DEFAULT,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             lk_valid,
   output logic             lk_ready,
   input  logic [WIDTH-1:0] lk_tag,
   input  logic [6:0]       lk_opcode,
   input  logic [N_RN-1:0]  lk_nid,
   input  logic [N_RN-1:0]  lk_sharers,
   output logic             snp_req_valid,
   input  logic             snp_req_ready,
   output logic [WIDTH-1:0] snp_req_tag,
   output logic [6:0]       snp_req_op,
   output logic [N_RN-1:0]  snp_req_nid,
   input  logic             snp_rsp_valid,
   output logic             snp_rsp_ready,
   input  logic [N_RN-1:0]  snp_rsp_nid,
   input  logic             snp_rsp_dirty,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] done_tag,
   output logic [N_RN-1:0]  done_sharers,
   output logic             done_dirty,
   output logic             done_err
);

   snoop_state_e     state_q, state_d;
   logic [WIDTH-1:0] tag_q, tag_d;
   logic [6:0]       op_q, op_d;
   logic [N_RN-1:0]  pending_q, pending_d;
   logic [N_RN-1:0]  sharers_q, sharers_d;
   logic             dirty_q, dirty_d;
   logic             err_q, err_d;
   logic [N_RN-1:0]  target;
   logic             rsp_match;

`ifdef SNOOP_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   lowest_one_sel #(.N(N_RN)) u_sel (
      .vec_i    (pending_q),
      .onehot_o (target)
   );

   assign rsp_match = snp_rsp_valid && (snp_rsp_nid == target);

   always_comb begin
      state_d   = state_q;
      tag_d     = tag_q;
      op_d      = op_q;
      pending_d = pending_q;
      sharers_d = sharers_q;
      dirty_d   = dirty_q;
      err_d     = err_q;
`ifdef SNOOP_TIMEOUT_EN
      tmo_d     = tmo_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (lk_valid) begin
               tag_d   = lk_tag;
               op_d    = lk_opcode;
               dirty_d = 1'b0;
               err_d   = 1'b0;
               // Final sharer vector is fixed at accept so a timeout cannot disturb it.
               case (lk_opcode)
                  READ_SHARED: begin
                     pending_d = lk_sharers & ~lk_nid;
                     sharers_d = lk_sharers | lk_nid;
                  end
                  READ_UNIQUE: begin
                     pending_d = lk_sharers & ~lk_nid;
                     sharers_d = lk_nid;
                  end
                  default: begin
                     pending_d = '0;
                     sharers_d = lk_sharers;
                     err_d     = 1'b1;
                  end
               endcase
               state_d = (pending_d != '0) ? ST_ISSUE : ST_DONE;
            end
         end
         ST_ISSUE: begin
            if (snp_req_ready) begin
               state_d = ST_WAIT_RSP;
`ifdef SNOOP_TIMEOUT_EN
               tmo_d   = TMO_LOAD;
`endif
            end
         end
         ST_WAIT_RSP: begin
            if (rsp_match) begin
               pending_d = pending_q & ~target;
               dirty_d   = dirty_q | snp_rsp_dirty;
               state_d   = (pending_d != '0) ? ST_ISSUE : ST_DONE;
            end else begin
               if (snp_rsp_valid) begin
                  err_d = 1'b1;
               end
`ifdef SNOOP_TIMEOUT_EN
               if (tmo_q == '0) begin
                  pending_d = '0;
                  err_d     = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  tmo_d = tmo_q - 1'b1;
               end
`endif
            end
         end
         ST_DONE: begin
            if (done_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         tag_q     <= '0;
         op_q      <= '0;
         pending_q <= '0;
         sharers_q <= '0;
         dirty_q   <= 1'b0;
         err_q     <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         tag_q     <= tag_d;
         op_q      <= op_d;
         pending_q <= pending_d;
         sharers_q <= sharers_d;
         dirty_q   <= dirty_d;
         err_q     <= err_d;
`ifdef SNOOP_TIMEOUT_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

   assign lk_ready      = (state_q == ST_IDLE);
   assign snp_rsp_ready = (state_q == ST_WAIT_RSP);

   assign snp_req_valid = (state_q == ST_ISSUE);
   assign snp_req_tag   = snp_req_valid ? tag_q : '0;
   assign snp_req_nid   = snp_req_valid ? target : '0;
   assign snp_req_op    = !snp_req_valid         ? 7'b0 :
                          (op_q == READ_UNIQUE)  ? SNP_UNIQUE : SNP_SHARED;

   assign done_valid    = (state_q == ST_DONE);
   assign done_tag      = done_valid ? tag_q : '0;
   assign done_sharers  = done_valid ? sharers_q : '0;
   assign done_dirty    = done_valid && dirty_q;
   assign done_err      = done_valid && err_q;

endmodule

// File: tb/tb_snoop_dispatcher.sv
// Directed bench for snoop_dispatcher; inputs driven and outputs sampled on negedge.
module tb_snoop_dispatcher;

   localparam int unsigned WIDTH   = 33;
   localparam int unsigned N_RN    = 7;
   localparam int unsigned TIMEOUT = 64;

   localparam logic [6:0] RD_SH  = 7'b0000001;
   localparam logic [6:0] RD_UN  = 7'b0000111;
   localparam logic [6:0] SNP_SH = 7'b0000001;
   localparam logic [6:0] SNP_UN = 7'b0000111;

   logic             clk = 1'b0;
   logic             reset;
   logic             lk_valid;
   logic             lk_ready;
   logic [WIDTH-1:0] lk_tag;
   logic [6:0]       lk_opcode;
   logic [N_RN-1:0]  lk_nid;
   logic [N_RN-1:0]  lk_sharers;
   logic             snp_req_valid;
   logic             snp_req_ready;
   logic [WIDTH-1:0] snp_req_tag;
   logic [6:0]       snp_req_op;
   logic [N_RN-1:0]  snp_req_nid;
   logic             snp_rsp_valid;
   logic             snp_rsp_ready;
   logic [N_RN-1:0]  snp_rsp_nid;
   logic             snp_rsp_dirty;
   logic             done_valid;
   logic             done_ready;
   logic [WIDTH-1:0] done_tag;
   logic [N_RN-1:0]  done_sharers;
   logic             done_dirty;
   logic             done_err;

   int n_vec = 0;
   int n_err = 0;
   int snoop_cnt = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   snoop_dispatcher #(.WIDTH(WIDTH), .N_RN(N_RN), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .reset         (reset),
      .lk_valid      (lk_valid),
      .lk_ready      (lk_ready),
      .lk_tag        (lk_tag),
      .lk_opcode     (lk_opcode),
      .lk_nid        (lk_nid),
      .lk_sharers    (lk_sharers),
      .snp_req_valid (snp_req_valid),
      .snp_req_ready (snp_req_ready),
      .snp_req_tag   (snp_req_tag),
      .snp_req_op    (snp_req_op),
      .snp_req_nid   (snp_req_nid),
      .snp_rsp_valid (snp_rsp_valid),
      .snp_rsp_ready (snp_rsp_ready),
      .snp_rsp_nid   (snp_rsp_nid),
      .snp_rsp_dirty (snp_rsp_dirty),
      .done_valid    (done_valid),
      .done_ready    (done_ready),
      .done_tag      (done_tag),
      .done_sharers  (done_sharers),
      .done_dirty    (done_dirty),
      .done_err      (done_err)
   );

   always @(posedge clk) begin
      if (!reset) begin
         if (snp_req_valid && snp_req_ready) snoop_cnt++;
         if (done_valid && done_ready) done_cnt++;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic start(input logic [WIDTH-1:0] tag, input logic [6:0] op,
                        input logic [N_RN-1:0] nid, input logic [N_RN-1:0] sh);
      lk_valid   = 1'b1;
      lk_tag     = tag;
      lk_opcode  = op;
      lk_nid     = nid;
      lk_sharers = sh;
      step();
      lk_valid   = 1'b0;
   endtask

   task automatic respond(input logic [N_RN-1:0] nid, input logic dirty);
      snp_rsp_valid = 1'b1;
      snp_rsp_nid   = nid;
      snp_rsp_dirty = dirty;
      step();
      snp_rsp_valid = 1'b0;
      snp_rsp_dirty = 1'b0;
   endtask

   initial begin
      int sc0, dc0, cnt;
      reset = 1'b1;
      lk_valid = 1'b0; lk_tag = '0; lk_opcode = '0; lk_nid = '0; lk_sharers = '0;
      snp_req_ready = 1'b1; snp_rsp_valid = 1'b0; snp_rsp_nid = '0; snp_rsp_dirty = 1'b0;
      done_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      check_eq("rst_lk_ready", 64'(lk_ready), 64'd1);
      check_eq("rst_valids", 64'({snp_req_valid, snp_rsp_ready, done_valid}), 64'd0);
      check_eq("rst_outs", 64'({snp_req_tag, snp_req_nid, snp_req_op, done_tag, done_sharers,
                                done_dirty, done_err}), 64'd0);
      step();

      // no snoop targets: completion the cycle after accept
      start(33'hABCDEFF, RD_SH, 7'b0000001, 7'b0000000);
      check_eq("t1_done_valid", 64'(done_valid), 64'd1);
      check_eq("t1_no_snoop", 64'(snp_req_valid), 64'd0);
      check_eq("t1_tag", 64'(done_tag), 64'h0ABCDEFF);
      check_eq("t1_sharers", 64'(done_sharers), 64'b0000001);
      check_eq("t1_dirty_err", 64'({done_dirty, done_err}), 64'd0);
      check_eq("t1_busy", 64'(lk_ready), 64'd0);
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
      check_eq("t1_idle", 64'({lk_ready, done_valid}), 64'b10);

      // READ_UNIQUE with two snoop targets, second one dirty
      start(33'h11223344, RD_UN, 7'b0000010, 7'b0000101);
      check_eq("t2_snp0_valid", 64'(snp_req_valid), 64'd1);
      check_eq("t2_snp0_nid", 64'(snp_req_nid), 64'b0000001);
      check_eq("t2_snp0_op", 64'(snp_req_op), 64'(SNP_UN));
      check_eq("t2_snp0_tag", 64'(snp_req_tag), 64'h11223344);
      step();
      check_eq("t2_wait", 64'({snp_rsp_ready, snp_req_valid}), 64'b10);
      respond(7'b0000001, 1'b0);
      check_eq("t2_snp1_nid", 64'(snp_req_nid), 64'b0000100);
      check_eq("t2_snp1_op", 64'(snp_req_op), 64'(SNP_UN));
      step();
      respond(7'b0000100, 1'b1);
      check_eq("t2_done_valid", 64'(done_valid), 64'd1);
      check_eq("t2_sharers", 64'(done_sharers), 64'b0000010);
      check_eq("t2_dirty", 64'(done_dirty), 64'd1);
      check_eq("t2_err", 64'(done_err), 64'd0);
      check_eq("t2_tag", 64'(done_tag), 64'h11223344);
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
      check_eq("t2_idle", 64'(lk_ready), 64'd1);

      // READ_SHARED single snoop; done_ready already high on DONE entry
      done_ready = 1'b1;
      start(33'h1_0000_0055, RD_SH, 7'b0000100, 7'b0000101);
      check_eq("t3_snp_nid", 64'(snp_req_nid), 64'b0000001);
      check_eq("t3_snp_op", 64'(snp_req_op), 64'(SNP_SH));
      step();
      respond(7'b0000001, 1'b0);
      check_eq("t3_done_pulse", 64'({done_valid, lk_ready}), 64'b10);
      check_eq("t3_sharers", 64'(done_sharers), 64'b0000101);
      check_eq("t3_dirty", 64'(done_dirty), 64'd0);
      step();
      check_eq("t3_turnaround", 64'({done_valid, lk_ready}), 64'b01);
      done_ready = 1'b0;

      // back-pressure on both channels; response coincident with snp_req_ready ignored
      snp_req_ready = 1'b0;
      sc0 = snoop_cnt;
      dc0 = done_cnt;
      start(33'h0_5A5A_5A5A, RD_UN, 7'b0001000, 7'b0011000);
      for (int i = 0; i < 5; i++) begin
         check_eq("t4_req_hold", 64'({snp_req_valid, snp_req_nid, snp_req_op, snp_req_tag}),
                  {23'd0, 1'b1, 7'b0010000, SNP_UN, 33'h0_5A5A_5A5A});
         step();
      end
      snp_req_ready = 1'b1;
      snp_rsp_valid = 1'b1; snp_rsp_nid = 7'b0010000; snp_rsp_dirty = 1'b1;
      step();
      snp_req_ready = 1'b0;
      snp_rsp_valid = 1'b0; snp_rsp_dirty = 1'b0;
      check_eq("t4_early_rsp_ignored", 64'({snp_rsp_ready, done_valid}), 64'b10);
      respond(7'b0010000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check_eq("t4_done_hold", 64'({done_valid, done_sharers, done_dirty, done_err, done_tag}),
                  {21'd0, 1'b1, 7'b0001000, 1'b0, 1'b0, 33'h0_5A5A_5A5A});
         step();
      end
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;
      snp_req_ready = 1'b1;
      check_eq("t4_idle", 64'({lk_ready, done_valid}), 64'b10);
      check_eq("t4_one_snoop", 64'(snoop_cnt - sc0), 64'd1);
      check_eq("t4_one_done", 64'(done_cnt - dc0), 64'd1);

      // mismatched responder sets err and is consumed without advancing
      start(33'h7, RD_SH, 7'b0000001, 7'b0000011);
      check_eq("t5_snp_nid", 64'(snp_req_nid), 64'b0000010);
      step();
      respond(7'b1000000, 1'b1);
      check_eq("t5_still_wait", 64'({snp_rsp_ready, done_valid}), 64'b10);
      respond(7'b0000010, 1'b0);
      check_eq("t5_done", 64'(done_valid), 64'd1);
      check_eq("t5_err", 64'(done_err), 64'd1);
      check_eq("t5_dirty", 64'(done_dirty), 64'd0);
      check_eq("t5_sharers", 64'(done_sharers), 64'b0000011);
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;

      // unknown opcode: no snoops, err, sharers passed through
      start(33'h42, 7'b0000010, 7'b0000001, 7'b0000110);
      check_eq("t6_no_snoop", 64'({snp_req_valid, done_valid}), 64'b01);
      check_eq("t6_err", 64'(done_err), 64'd1);
      check_eq("t6_sharers", 64'(done_sharers), 64'b0000110);
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;

      // no response at all
      start(33'h99, RD_UN, 7'b0000001, 7'b0000010);
      step();
      cnt = 0;
      while (!done_valid && cnt < 200) begin
         step();
         cnt++;
      end
`ifdef SNOOP_TIMEOUT_EN
      check_eq("t7_timeout_cycles", 64'(cnt), 64'(TIMEOUT));
      check_eq("t7_err", 64'(done_err), 64'd1);
      check_eq("t7_sharers", 64'(done_sharers), 64'b0000001);
`else
      check_eq("t7_waits_forever", 64'({done_valid, snp_rsp_ready}), 64'b01);
      respond(7'b0000010, 1'b1);
      check_eq("t7_late_done", 64'({done_valid, done_err, done_dirty}), 64'b101);
      check_eq("t7_sharers", 64'(done_sharers), 64'b0000001);
`endif
      done_ready = 1'b1;
      step();
      done_ready = 1'b0;

      // reset while waiting for a response aborts with no completion
      dc0 = done_cnt;
      start(33'h1234, RD_UN, 7'b0000001, 7'b0000010);
      step();
      check_eq("t8_in_wait", 64'(snp_rsp_ready), 64'd1);
      reset = 1'b1;
      step();
      check_eq("t8_rst_state", 64'({lk_ready, snp_req_valid, snp_rsp_ready, done_valid}), 64'b1000);
      reset = 1'b0;
      done_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("t8_no_done", 64'({lk_ready, done_valid, snp_req_valid}), 64'b100);
      end
      done_ready = 1'b0;
      check_eq("t8_done_cnt", 64'(done_cnt - dc0), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
